// File: rtl/btc_sequencer.sv
// Tile sequencer for one bTensorCore: walks a K x N tiled GEMM job, handshaking the
// weight/activation tile buffers, strobing the core and handing each finished tile downstream.
module btc_sequencer #(
    parameter int K_W      = 8,
    parameter int N_W      = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [K_W-1:0] cmd_k_tiles,
    input  logic [N_W-1:0] cmd_n_tiles,
    input  logic           w_valid,
    output logic           w_ready,
    input  logic           a_valid,
    output logic           a_ready,
    output logic           weight_update,
    output logic           activation_update,
    output logic           psum_update,
    output logic           psum_sel,
    output logic [K_W-1:0] k_idx,
    output logic [N_W-1:0] n_idx,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_last,
    output logic           busy,
    output logic           done
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PIPE_LAT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_LOAD_A = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [K_W-1:0]   k_idx_q, k_idx_d;
    logic [N_W-1:0]   n_idx_q, n_idx_d;
    logic [K_W-1:0]   k_tiles_q, k_tiles_d;
    logic [N_W-1:0]   n_tiles_q, n_tiles_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic in_idle, in_load_w, in_load_a, in_out, in_done;
    logic k_last, n_last;

    // Every state decode is qualified by rst so all outputs read zero while reset is held.
    assign in_idle   = rst && (state_q == S_IDLE);
    assign in_load_w = rst && (state_q == S_LOAD_W);
    assign in_load_a = rst && (state_q == S_LOAD_A);
    assign in_out    = rst && (state_q == S_OUT);
    assign in_done   = rst && (state_q == S_DONE);

    // Equality against count-1 never lets the index pass the latched count, so 2^W-1 cannot wrap.
    assign k_last = (k_idx_q == k_tiles_q - K_W'(1));
    assign n_last = (n_idx_q == n_tiles_q - N_W'(1));

    always_comb begin
        state_d   = state_q;
        k_idx_d   = k_idx_q;
        n_idx_d   = n_idx_q;
        k_tiles_d = k_tiles_q;
        n_tiles_d = n_tiles_q;
        wait_d    = wait_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    k_tiles_d = cmd_k_tiles;
                    n_tiles_d = cmd_n_tiles;
                    k_idx_d   = '0;
                    n_idx_d   = '0;
                    if ((cmd_k_tiles == '0) || (cmd_n_tiles == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (a_valid) begin
                    wait_d  = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    if (!k_last) begin
                        k_idx_d = k_idx_q + K_W'(1);
                        state_d = S_LOAD_A;
                    end else begin
                        state_d = S_OUT;
                    end
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    if (n_last) begin
                        state_d = S_DONE;
                    end else begin
                        n_idx_d = n_idx_q + N_W'(1);
                        k_idx_d = '0;
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_idx_q   <= '0;
            n_idx_q   <= '0;
            k_tiles_q <= '0;
            n_tiles_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_idx_q   <= k_idx_d;
            n_idx_q   <= n_idx_d;
            k_tiles_q <= k_tiles_d;
            n_tiles_q <= n_tiles_d;
            wait_q    <= wait_d;
        end
    end

    assign cmd_ready         = in_idle;
    assign w_ready           = in_load_w;
    assign a_ready           = in_load_a;
    assign weight_update     = in_load_w && w_valid;
    assign activation_update = in_load_a && a_valid;
    assign psum_update       = in_load_a && a_valid;
    assign psum_sel          = in_load_a && (k_idx_q != '0);
    assign k_idx             = rst ? k_idx_q : '0;
    assign n_idx             = rst ? n_idx_q : '0;
    assign res_valid         = in_out;
    assign res_last          = in_out && n_last;
    assign busy              = rst && (state_q != S_IDLE);
    assign done              = in_done;

endmodule
